// File: rtl/noc_flit_injector_pkg.sv
// noc_flit_injector_pkg: shared FSM encoding and field-width helper for the flit injector
package noc_flit_injector_pkg;
    typedef enum logic [0:0] {IDLE, SEND} state_t;
    function automatic int field_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: saturating per-VC credit counter with sticky overflow flag
module noc_credit_counter
    import noc_flit_injector_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             err
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_W'(CREDITS);
            err <= 1'b0;
        end else if (inc && !dec) begin
            if (count == CNT_W'(CREDITS)) err <= 1'b1;
            else count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/noc_flit_injector.sv
// noc_flit_injector: turns packet requests plus payload words into credit-checked flits
// for a CONNECT send port, one flit per cycle.
module noc_flit_injector
    import noc_flit_injector_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH = 64,
    parameter int NUM_VCS = 2,
    parameter int NUM_DESTS = 9,
    parameter int CREDITS_PER_VC = 4,
    parameter int MAX_PKT_FLITS = 8,
    localparam int VC_BITS = field_bits(NUM_VCS),
    localparam int DEST_BITS = field_bits(NUM_DESTS),
    localparam int LEN_BITS = $clog2(MAX_PKT_FLITS + 1),
    localparam int CNT_W = $clog2(CREDITS_PER_VC + 1),
    localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DEST_BITS-1:0]       req_dest,
    input  logic [VC_BITS-1:0]         req_vc,
    input  logic [LEN_BITS-1:0]        req_len,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic [FLIT_DATA_WIDTH-1:0] data_in,
    output logic [FLIT_W-1:0]          flit_out,
    output logic                       flit_send,
    input  logic [VC_BITS:0]           credit_in,
    output logic [NUM_VCS*CNT_W-1:0]   credit_count,
    output logic [31:0]                pkts_sent,
    output logic                       credit_err,
    output logic                       busy
);
    state_t state;
    logic [DEST_BITS-1:0] dest;
    logic [VC_BITS-1:0] cur_vc;
    logic [LEN_BITS-1:0] len, idx;
    logic [CNT_W-1:0] cnt [NUM_VCS];
    logic [NUM_VCS-1:0] dec, inc, err;
    logic xfer, tail;

    assign busy = state == SEND;
    assign req_ready = !busy && !reset;
    assign data_ready = busy && cnt[cur_vc] != '0;
    assign xfer = data_ready && data_valid;
    assign tail = idx == len - 1'b1;
    assign credit_err = |err;

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign dec[v] = xfer && cur_vc == VC_BITS'(v);
        assign inc[v] = credit_in[VC_BITS] && credit_in[VC_BITS-1:0] == VC_BITS'(v);
        assign credit_count[v*CNT_W +: CNT_W] = cnt[v];
        noc_credit_counter #(.CREDITS(CREDITS_PER_VC), .CNT_W(CNT_W)) u_cnt (
            .clk(Clk),
            .rst(reset),
            .dec(dec[v]),
            .inc(inc[v]),
            .count(cnt[v]),
            .err(err[v])
        );
    end

    // Reset mid-packet drops the packet silently: no tail is ever emitted for it.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= IDLE;
            flit_out <= '0;
            flit_send <= 1'b0;
            pkts_sent <= '0;
            dest <= '0;
            cur_vc <= '0;
            len <= '0;
            idx <= '0;
        end else begin
            flit_send <= xfer;
            flit_out <= xfer ? {1'b1, tail, dest, cur_vc, data_in} : '0;
            if (!busy && req_valid) begin
                state <= SEND;
                dest <= req_dest;
                cur_vc <= req_vc;
                len <= req_len == '0 ? LEN_BITS'(1) : req_len;
                idx <= '0;
            end
            if (xfer) begin
                idx <= idx + 1'b1;
                if (tail) begin
                    state <= IDLE;
                    pkts_sent <= pkts_sent + 32'd1;
                end
            end
        end
    end
endmodule
